// File: rtl/sync_fifo_th2.sv
// Single-clock FIFO, any depth 2..256, with level/threshold status and sticky ovf/udf flags.
// Latency: FWFT data visible the cycle after the write (RD_REG=0), or one cycle after rd_en (RD_REG=1).
// Backpressure: writes are dropped while full and reads while empty; each drop sets a sticky error flag.
module sync_fifo_th2 #(
    parameter int W      = 8,
    parameter int DP     = 16,
    parameter int AW     = $clog2(DP + 1),
    parameter bit RD_REG = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic          full,
    output logic          afull,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          aempty,
    input  logic [AW-1:0] cfg_afull_th,
    input  logic [AW-1:0] cfg_aempty_th,
    output logic [AW-1:0] level,
    output logic [AW-1:0] free_space,
    input  logic          err_clr,
    output logic          ovf_err,
    output logic          udf_err
);
    localparam int            PW       = $clog2(DP);
    localparam logic [AW-1:0] DP_L     = AW'(DP);
    localparam logic [PW-1:0] PTR_LAST = PW'(DP - 1);

    logic [W-1:0]  mem_q [DP];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          wr_acc, rd_acc;

    assign full       = (level_q == DP_L);
    assign empty      = (level_q == '0);
    assign afull      = (level_q >= cfg_afull_th);
    assign aempty     = (level_q <= cfg_aempty_th);
    assign level      = level_q;
    assign free_space = DP_L - level_q;
    assign ovf_err    = ovf_q;
    assign udf_err    = udf_q;

    always_comb begin
        wr_acc   = wr_en & ~full & ~flush;
        rd_acc   = rd_en & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // a fresh error event outranks a clear arriving in the same cycle
        ovf_d    = (wr_en & full & ~flush) | (ovf_q & ~err_clr);
        udf_d    = (rd_en & empty & ~flush) | (udf_q & ~err_clr);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            if (wr_acc && !rd_acc)      level_d = level_q + 1'b1;
            else if (rd_acc && !wr_acc) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    generate
        if (RD_REG) begin : g_rd_reg
            logic [W-1:0] rd_data_q, rd_data_d;
            logic         rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = rd_acc;
                if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_rd_fwft
            assign rd_data  = mem_q[rd_ptr_q];
            assign rd_valid = ~empty;
        end
    endgenerate

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (level_q <= DP_L) else $error("sync_fifo_th2: level above depth");
            assert (({1'b0, level_q} + {1'b0, free_space}) == {1'b0, DP_L})
                else $error("sync_fifo_th2: level + free_space != depth");
            assert (!(full && empty)) else $error("sync_fifo_th2: full and empty together");
            if (wr_en && full && !flush)  $warning("sync_fifo_th2: write dropped while full");
            if (rd_en && empty && !flush) $warning("sync_fifo_th2: read dropped while empty");
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_th2.sv
module tb_sync_fifo_th2;
    localparam int DPA = 5;
    localparam int AWA = 3;
    localparam int DPB = 16;
    localparam int AWB = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] wr_data = 8'h00;

    always #5 clk = ~clk;

    logic           a_full, a_afull, a_empty, a_aempty, a_rd_valid, a_ovf, a_udf;
    logic [7:0]     a_rd_data;
    logic [AWA-1:0] a_level, a_free, a_afull_th, a_aempty_th;
    logic           b_full, b_afull, b_empty, b_aempty, b_rd_valid, b_ovf, b_udf;
    logic [7:0]     b_rd_data;
    logic [AWB-1:0] b_level, b_free, b_afull_th, b_aempty_th;

    sync_fifo_th2 #(.W(8), .DP(DPA), .RD_REG(1'b0)) u_fwft (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .full(a_full), .afull(a_afull),
        .rd_en(rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .empty(a_empty), .aempty(a_aempty),
        .cfg_afull_th(a_afull_th), .cfg_aempty_th(a_aempty_th),
        .level(a_level), .free_space(a_free),
        .err_clr(err_clr), .ovf_err(a_ovf), .udf_err(a_udf)
    );

    sync_fifo_th2 #(.W(8), .DP(DPB), .RD_REG(1'b1)) u_reg (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .full(b_full), .afull(b_afull),
        .rd_en(rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .empty(b_empty), .aempty(b_aempty),
        .cfg_afull_th(b_afull_th), .cfg_aempty_th(b_aempty_th),
        .level(b_level), .free_space(b_free),
        .err_clr(err_clr), .ovf_err(b_ovf), .udf_err(b_udf)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       m_ovf_a = 1'b0, m_udf_a = 1'b0, m_ovf_b = 1'b0, m_udf_b = 1'b0;
    logic       m_bv = 1'b0;
    logic [7:0] m_bd = 8'h00;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        int sa;
        int sb;
        sa = qa.size();
        sb = qb.size();
        chk("a_level",    a_level, sa);
        chk("a_free",     a_free, DPA - sa);
        chk("a_empty",    a_empty, sa == 0);
        chk("a_full",     a_full, sa == DPA);
        chk("a_afull",    a_afull, sa >= int'(a_afull_th));
        chk("a_aempty",   a_aempty, sa <= int'(a_aempty_th));
        chk("a_rd_valid", a_rd_valid, sa != 0);
        chk("a_ovf",      a_ovf, m_ovf_a);
        chk("a_udf",      a_udf, m_udf_a);
        chk("b_level",    b_level, sb);
        chk("b_free",     b_free, DPB - sb);
        chk("b_empty",    b_empty, sb == 0);
        chk("b_full",     b_full, sb == DPB);
        chk("b_afull",    b_afull, sb >= int'(b_afull_th));
        chk("b_aempty",   b_aempty, sb <= int'(b_aempty_th));
        chk("b_rd_valid", b_rd_valid, m_bv);
        chk("b_rd_data",  b_rd_data, m_bd);
        chk("b_ovf",      b_ovf, m_ovf_b);
        chk("b_udf",      b_udf, m_udf_b);
    endtask

    task automatic do_reset(input logic busy);
        reset   = 1'b1;
        wr_en   = busy;
        rd_en   = busy;
        wr_data = 8'hEE;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        qa.delete();
        qb.delete();
        m_ovf_a = 1'b0; m_udf_a = 1'b0;
        m_ovf_b = 1'b0; m_udf_b = 1'b0;
        m_bv = 1'b0;
        m_bd = 8'h00;
        check_state();
    endtask

    task automatic step(input logic wr, input logic [7:0] wd, input logic rd,
                        input logic fl = 1'b0, input logic ec = 1'b0);
        int   pa;
        int   pb;
        logic wa_a, ra_a, wa_b, ra_b;
        pa   = qa.size();
        pb   = qb.size();
        wa_a = wr && !fl && (pa < DPA);
        ra_a = rd && !fl && (pa > 0);
        wa_b = wr && !fl && (pb < DPB);
        ra_b = rd && !fl && (pb > 0);
        wr_en = wr; wr_data = wd; rd_en = rd; flush = fl; err_clr = ec;
        if (ra_a) chk("a_fwft_data", a_rd_data, qa[0]);
        m_ovf_a = (wr && !fl && pa == DPA) || (m_ovf_a && !ec);
        m_udf_a = (rd && !fl && pa == 0)   || (m_udf_a && !ec);
        m_ovf_b = (wr && !fl && pb == DPB) || (m_ovf_b && !ec);
        m_udf_b = (rd && !fl && pb == 0)   || (m_udf_b && !ec);
        m_bv    = ra_b;
        if (fl) begin
            qa.delete();
            qb.delete();
        end else begin
            if (ra_a) void'(qa.pop_front());
            if (wa_a) qa.push_back(wd);
            if (ra_b) m_bd = qb.pop_front();
            if (wa_b) qb.push_back(wd);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        check_state();
    endtask

    initial begin
        a_afull_th = 3'd6;  a_aempty_th = 3'd1;
        b_afull_th = 5'd12; b_aempty_th = 5'd2;
        do_reset(1'b0);

        // zero almost-full threshold asserts afull on an empty FIFO
        a_afull_th = 3'd0;
        #1 check_state();
        a_afull_th = 3'd6;
        #1 check_state();

        // fill DP=5 to full, overflow, drain in order, underflow
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
        step(1'b1, 8'h16, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // steady level 3 with simultaneous traffic, pointers wrap
        a_afull_th = 3'd4; a_aempty_th = 3'd1;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h21 + i), 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

        // fill DP=16 through the thresholds, then wr+rd at full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b1, 8'h99, 1'b1);
        b_afull_th = 5'd16;
        #1 check_state();
        b_afull_th = 5'd12;
        #1 check_state();
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // wr+rd on empty: write lands, read rejected, then registered read
        step(1'b1, 8'hA5, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // flush at level 7 with wr_en, then err_clr racing an underflow
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // reset mid-stream at level 9
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        do_reset(1'b1);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_th2.md
Name: sync_fifo_th2

Overview:
Single-clock synchronous FIFO with programmable almost-full and almost-empty thresholds, occupancy and free-space reporting, and sticky overflow/underflow error flags. Depth is any integer from 2 to 256, not limited to powers of two. The read port can be first-word-fall-through or registered, and the FIFO can be flushed synchronously. It is the single-clock-domain companion of the threshold-tracking async FIFO, for peripheral TX/RX buffering where both sides run on one clock.

Parameters:
W, 8, data width in bits (1..64)
DP, 16, FIFO depth in entries (2..256, any integer)
AW, $clog2(DP+1), width of the level fields; derived, do not override
RD_REG, 0, 0 = FWFT (combinational rd_data), 1 = registered read data with 1-cycle latency

Ports:
clk  input  1  FIFO clock
reset  input  1  synchronous active-high reset
flush  input  1  synchronous FIFO clear
wr_en  input  1  write request
wr_data  input  W  write data
full  output  1  level == DP
afull  output  1  level >= cfg_afull_th
rd_en  input  1  read request
rd_data  output  W  read data
rd_valid  output  1  RD_REG=1: rd_data valid strobe; RD_REG=0: equals !empty
empty  output  1  level == 0
aempty  output  1  level <= cfg_aempty_th
cfg_afull_th  input  AW  almost-full threshold, quasi-static
cfg_aempty_th  input  AW  almost-empty threshold, quasi-static
level  output  AW  current occupancy, 0..DP
free_space  output  AW  DP - level
err_clr  input  1  clear sticky error flags
ovf_err  output  1  sticky: write attempted while full
udf_err  output  1  sticky: read attempted while empty

Behaviour:
- Reset (clk edge with reset=1):
  - wr_ptr=0, rd_ptr=0, level=0, ovf_err=0, udf_err=0, rd_valid=0, rd_data=0 when RD_REG=1.
  - Hence empty=1, full=0, free_space=DP, aempty=1.
  - afull=1 only if cfg_afull_th==0.
  - Memory contents are not reset.
- Pointers run 0..DP-1 and wrap explicitly to 0 after DP-1. No power-of-2 masking.
- level is a registered counter. All flags are combinational from the registered level, so a status change is visible the cycle after the causing edge.
- Write acceptance: wr_acc = wr_en & !full. On acceptance, mem[wr_ptr] <= wr_data and wr_ptr advances.
- Read acceptance: rd_acc = rd_en & !empty, where empty is the pre-edge value. On acceptance, rd_ptr advances.
- Level update:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged when both are accepted or neither is.
- Simultaneous requests:
  - At full: write is rejected (ovf_err set); the read is accepted; level becomes DP-1.
  - At empty: write is accepted; the read is rejected (udf_err set); level becomes 1. No write-through bypass.
- FWFT read (RD_REG=0): rd_data = mem[rd_ptr] continuously; the data is valid while !empty.
- Registered read (RD_REG=1):
  - On rd_acc: rd_data <= mem[rd_ptr] and rd_valid <= 1; otherwise rd_valid <= 0.
  - rd_data holds its last value when there is no read.
- Flush:
  - Priority is reset > flush > wr/rd.
  - On flush, pointers and level go to 0 and rd_valid goes to 0.
  - wr_en and rd_en in the same cycle are ignored, and no error flags are set for them.
  - Sticky error flags are not cleared by flush.
- Error flags:
  - ovf_err is set on wr_en & full; udf_err is set on rd_en & empty.
  - err_clr clears both.
  - If a set condition and err_clr occur in the same cycle, the set wins.
- Thresholds:
  - Compared unsigned against level.
  - A cfg_afull_th > DP makes afull never assert.
  - A change in either threshold takes effect combinationally.
- Invariants that must always hold: level <= DP; level + free_space == DP; full and empty are never both 1.
- Simulation-only: assertions on the invariants above, and a warning message on overflow or underflow. No $stop.

Test Plan:
- DP=5, RD_REG=0. Write 5 words (0x11..0x15). Then full=1, level=5, free_space=0. A 6th write sets ovf_err=1 and leaves the contents unchanged. Reading 5 words returns 0x11..0x15 in order, then empty=1.
- DP=5, level=3, wr_en=rd_en=1 for 7 cycles: level stays 3, and the pointers wrap past 4 to 0 with no data corruption. Check the read sequence against a scoreboard.
- DP=16, cfg_afull_th=12, cfg_aempty_th=2. Fill from 0 to 16: aempty=1 for levels 0..2, afull=1 from level 12. At level 16, a simultaneous wr+rd gives level 15 and ovf_err=1.
- RD_REG=1, empty FIFO. wr+rd in the same cycle: write accepted, udf_err=1, level=1. The next cycle's rd_en gives rd_valid=1 one cycle later with the written data.
- Level 7, flush with wr_en=1: the next cycle shows level=0, empty=1, ovf_err unchanged. err_clr asserted in the same cycle as rd_en&empty leaves udf_err=1.
- Reset asserted mid-stream at level 9: the next cycle shows level=0, empty=1, ovf_err=0, udf_err=0, rd_valid=0.
